// File: rtl/pwr_seq_fsm.sv
// Board power sequencer: orders the P1V8/P3V3/P1V1 enables, BMC resets and CPU POR,
// with power-good timeouts, sticky fault capture and an ordered power-down.
module pwr_seq_fsm #(
  parameter int DLY_P1V8_MS   = 6,
  parameter int DLY_P3V3_MS   = 6,
  parameter int DLY_P1V1_MS   = 6,
  parameter int DLY_RST_MS    = 10,
  parameter int DLY_POR_MS    = 400,
  parameter int PG_TIMEOUT_MS = 100,
  parameter int CNT_W         = 11
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       ms_pulse,
  input  logic       vcore_en,
  input  logic       vcore_pwrgd,
  input  logic       p1v8_pwrgd,
  input  logic       p3v3_pwrgd,
  input  logic       p1v1_pwrgd,
  output logic       p1v8_en,
  output logic       p3v3_en,
  output logic       p1v1_en,
  output logic       bmc_pcie_rst_n,
  output logic       bmc_phy_rst_n,
  output logic       cpu_por_n,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [3:0] seq_state
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_DLY_1V8  = 4'd1;
  localparam logic [3:0] S_PG_1V8   = 4'd2;
  localparam logic [3:0] S_DLY_3V3  = 4'd3;
  localparam logic [3:0] S_PG_3V3   = 4'd4;
  localparam logic [3:0] S_DLY_1V1  = 4'd5;
  localparam logic [3:0] S_PG_1V1   = 4'd6;
  localparam logic [3:0] S_RST_WAIT = 4'd7;
  localparam logic [3:0] S_POR_WAIT = 4'd8;
  localparam logic [3:0] S_ON       = 4'd9;
  localparam logic [3:0] S_PWR_DOWN = 4'd10;
  localparam logic [3:0] S_FAULT    = 4'd11;

  localparam logic [CNT_W-1:0] LAST_P1V8 = CNT_W'(DLY_P1V8_MS - 1);
  localparam logic [CNT_W-1:0] LAST_P3V3 = CNT_W'(DLY_P3V3_MS - 1);
  localparam logic [CNT_W-1:0] LAST_P1V1 = CNT_W'(DLY_P1V1_MS - 1);
  localparam logic [CNT_W-1:0] LAST_RST  = CNT_W'(DLY_RST_MS - 1);
  localparam logic [CNT_W-1:0] LAST_POR  = CNT_W'(DLY_POR_MS - 1);
  localparam logic [CNT_W-1:0] LAST_PG   = CNT_W'(PG_TIMEOUT_MS - 1);
  localparam logic [CNT_W-1:0] PD_P3V3   = CNT_W'(0);
  localparam logic [CNT_W-1:0] PD_P1V8   = CNT_W'(1);
  localparam logic [CNT_W-1:0] PD_LAST   = CNT_W'(2);

  logic [4:0]       sync_a;
  logic [4:0]       sync_b;
  logic             en_s;
  logic             vcore_pg;
  logic             p1v8_pg;
  logic             p3v3_pg;
  logic             p1v1_pg;
  logic [3:0]       state;
  logic [3:0]       state_d;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       code_d;
  logic             in_run;
  logic             pg_expired;
  logic             pd_req;
  logic             pass_1v8;
  logic             pass_3v3;
  logic             pass_1v1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {vcore_en, vcore_pwrgd, p1v8_pwrgd, p3v3_pwrgd, p1v1_pwrgd};
      sync_b <= sync_a;
    end
  end

  assign {en_s, vcore_pg, p1v8_pg, p3v3_pg, p1v1_pg} = sync_b;

  // Fault causes are tested lowest code first; a rail is only watched once it
  // has passed its power-good check and is still enabled.
  always_comb begin
    in_run     = (state >= S_DLY_1V8) && (state <= S_PWR_DOWN);
    pg_expired = ms_pulse && (cnt == LAST_PG);
    pd_req     = !en_s && (state >= S_DLY_1V8) && (state <= S_ON);
    code_d     = 3'd0;
    if (state == S_PG_1V8 && pg_expired)                      code_d = 3'd1;
    else if (state == S_PG_3V3 && pg_expired)                 code_d = 3'd2;
    else if (state == S_PG_1V1 && pg_expired)                 code_d = 3'd3;
    else if (in_run && !vcore_pg)                             code_d = 3'd4;
    else if (in_run && pass_1v8 && p1v8_en && !p1v8_pg)       code_d = 3'd5;
    else if (in_run && pass_3v3 && p3v3_en && !p3v3_pg)       code_d = 3'd6;
    else if (in_run && pass_1v1 && p1v1_en && !p1v1_pg)       code_d = 3'd7;

    state_d = state;
    if (code_d != 3'd0) begin
      state_d = S_FAULT;
    end else if (pd_req) begin
      state_d = S_PWR_DOWN;
    end else begin
      case (state)
        S_IDLE:     if (en_s && vcore_pg)                  state_d = S_DLY_1V8;
        S_DLY_1V8:  if (ms_pulse && cnt == LAST_P1V8)      state_d = S_PG_1V8;
        S_PG_1V8:   if (p1v8_pg)                           state_d = S_DLY_3V3;
        S_DLY_3V3:  if (ms_pulse && cnt == LAST_P3V3)      state_d = S_PG_3V3;
        S_PG_3V3:   if (p3v3_pg)                           state_d = S_DLY_1V1;
        S_DLY_1V1:  if (ms_pulse && cnt == LAST_P1V1)      state_d = S_PG_1V1;
        S_PG_1V1:   if (p1v1_pg)                           state_d = S_RST_WAIT;
        S_RST_WAIT: if (ms_pulse && cnt == LAST_RST)       state_d = S_POR_WAIT;
        S_POR_WAIT: if (ms_pulse && cnt == LAST_POR)       state_d = S_ON;
        S_ON:                                              state_d = S_ON;
        S_PWR_DOWN: if (ms_pulse && cnt == PD_LAST)        state_d = S_IDLE;
        S_FAULT:    if (!en_s)                             state_d = S_IDLE;
        default:                                           state_d = S_IDLE;
      endcase
    end
  end

  // POR_WAIT keeps counting from RST_WAIT so the POR delay is measured from P1V1 good.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      pass_1v8       <= 1'b0;
      pass_3v3       <= 1'b0;
      pass_1v1       <= 1'b0;
      p1v8_en        <= 1'b0;
      p3v3_en        <= 1'b0;
      p1v1_en        <= 1'b0;
      bmc_pcie_rst_n <= 1'b0;
      bmc_phy_rst_n  <= 1'b0;
      cpu_por_n      <= 1'b0;
      fault          <= 1'b0;
      fault_code     <= 3'd0;
    end else begin
      state <= state_d;
      if (state_d != state && state_d != S_POR_WAIT) cnt <= '0;
      else if (ms_pulse)                             cnt <= cnt + CNT_W'(1);

      if (state_d != state) begin
        case (state_d)
          S_IDLE: begin
            p1v8_en        <= 1'b0;
            p3v3_en        <= 1'b0;
            p1v1_en        <= 1'b0;
            bmc_pcie_rst_n <= 1'b0;
            bmc_phy_rst_n  <= 1'b0;
            cpu_por_n      <= 1'b0;
            fault          <= 1'b0;
            fault_code     <= 3'd0;
            pass_1v8       <= 1'b0;
            pass_3v3       <= 1'b0;
            pass_1v1       <= 1'b0;
          end
          S_PG_1V8:   p1v8_en  <= 1'b1;
          S_DLY_3V3:  pass_1v8 <= 1'b1;
          S_PG_3V3:   p3v3_en  <= 1'b1;
          S_DLY_1V1:  pass_3v3 <= 1'b1;
          S_PG_1V1:   p1v1_en  <= 1'b1;
          S_RST_WAIT: pass_1v1 <= 1'b1;
          S_POR_WAIT: begin
            bmc_pcie_rst_n <= 1'b1;
            bmc_phy_rst_n  <= 1'b1;
          end
          S_ON:       cpu_por_n <= 1'b1;
          S_PWR_DOWN: begin
            cpu_por_n      <= 1'b0;
            bmc_pcie_rst_n <= 1'b0;
            bmc_phy_rst_n  <= 1'b0;
            p1v1_en        <= 1'b0;
          end
          S_FAULT: begin
            p1v8_en        <= 1'b0;
            p3v3_en        <= 1'b0;
            p1v1_en        <= 1'b0;
            bmc_pcie_rst_n <= 1'b0;
            bmc_phy_rst_n  <= 1'b0;
            cpu_por_n      <= 1'b0;
            fault          <= 1'b1;
            fault_code     <= code_d;
            pass_1v8       <= 1'b0;
            pass_3v3       <= 1'b0;
            pass_1v1       <= 1'b0;
          end
          default: ;
        endcase
      end else if (state == S_PWR_DOWN && ms_pulse) begin
        if (cnt == PD_P3V3) p3v3_en <= 1'b0;
        if (cnt == PD_P1V8) p1v8_en <= 1'b0;
      end
    end
  end

  assign seq_state = state;

endmodule

// File: doc/pwr_seq_fsm.md
# pwr_seq_fsm

Board power-up/power-down sequencer for the BMU CPLD. It consumes the 1 ms strobe from the shared timer chain and the rail power-good inputs. It drives the P1V8/P3V3/P1V1 enables, the BMC PCIe/PHY resets and CPU POR. It replaces the per-rail `timer_n_ms` instances with one state machine that adds power-good timeouts, fault latching and an ordered power-down.

## Interface
Parameters:
- `DLY_P1V8_MS`, 6: delay from VCORE good to `p1v8_en`.
- `DLY_P3V3_MS`, 6: delay from P1V8 good to `p3v3_en`.
- `DLY_P1V1_MS`, 6: delay from P3V3 good to `p1v1_en`.
- `DLY_RST_MS`, 10: delay from P1V1 good to release of the PCIe/PHY resets.
- `DLY_POR_MS`, 400: delay from P1V1 good to release of `cpu_por_n`. Must be greater than `DLY_RST_MS`.
- `PG_TIMEOUT_MS`, 100: maximum wait for a rail's power-good after its enable.
- `CNT_W`, 11: width of the ms counter. Must satisfy 2^CNT_W > every delay parameter.

Ports:
- `sys_clk`  in  1  50 MHz system clock.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `ms_pulse`  in  1  one-cycle strobe every 1 ms, from `timer_1ms`.
- `vcore_en`  in  1  power request (asynchronous).
- `vcore_pwrgd`, `p1v8_pwrgd`, `p3v3_pwrgd`, `p1v1_pwrgd`  in  1 each  rail power-good inputs (asynchronous).
- `p1v8_en`, `p3v3_en`, `p1v1_en`  out  1 each  rail enables.
- `bmc_pcie_rst_n`, `bmc_phy_rst_n`  out  1 each  BMC PCIe/PHY resets, active low.
- `cpu_por_n`  out  1  CPU power-on reset, active low.
- `fault`  out  1  sticky fault flag.
- `fault_code`  out  3  cause of the latched fault.
- `seq_state`  out  4  current state encoding, for debug LEDs or I2C readback.

## Operation
- All five asynchronous inputs pass through 2-flop synchronizers. All logic below uses the synchronized values.
- An ms counter (`CNT_W` bits) increments on `ms_pulse` and clears on entry to every state except POR_WAIT. A delay of N completes on the Nth `ms_pulse` after state entry, when cnt == N-1 and `ms_pulse` is high. All delay parameters are at least 1.
- States (`seq_state` encoding):
  - 0 IDLE: all outputs deasserted. Go to DLY_1V8 when `vcore_en` and `vcore_pwrgd` are both high.
  - 1 DLY_1V8: wait `DLY_P1V8_MS`, then set `p1v8_en` and go to PG_1V8.
  - 2 PG_1V8: on `p1v8_pwrgd` go to DLY_3V3. If `PG_TIMEOUT_MS` expires first, go to FAULT with code 1.
  - 3 DLY_3V3 and 4 PG_3V3: same pattern; timeout code 2.
  - 5 DLY_1V1 and 6 PG_1V1: same pattern; timeout code 3.
  - 7 RST_WAIT: wait `DLY_RST_MS`, then release both BMC resets and go to POR_WAIT. The counter is not cleared.
  - 8 POR_WAIT: when cnt reaches `DLY_POR_MS`-1 with `ms_pulse`, release `cpu_por_n` and go to ON.
  - 9 ON: all outputs asserted. Hold until a fault or a power-down request.
  - 10 PWR_DOWN: on entry, drive `cpu_por_n` and both resets low and clear `p1v1_en`. Clear `p3v3_en` on the 1st `ms_pulse` and `p1v8_en` on the 2nd. Go to IDLE on the 3rd.
  - 11 FAULT: all enables and resets deasserted in the entry cycle. `fault`=1 with `fault_code` held. Leave to IDLE only when `vcore_en` is low; `fault` and `fault_code` clear on that transition.
- Rail-loss faults:
  - `vcore_pwrgd` low in any state 1-10: code 4.
  - `p1v8_pwrgd` low in any state after PG_1V8 has passed: code 5.
  - `p3v3_pwrgd` low in any state after PG_3V3 has passed: code 6.
  - `p1v1_pwrgd` low in any state after PG_1V1 has passed: code 7.
- Rail-loss checks are suppressed in PWR_DOWN for rails already disabled.
- `vcore_en` low in states 1-9 sends the machine to PWR_DOWN.
- Priority when events coincide in the same cycle: rail loss or timeout, then power-down request, then normal advance. If several faults coincide, the lowest code wins.
- `fault` and `fault_code` are written only on entry to FAULT.

## Timing
- Reset values: all enables 0, `bmc_pcie_rst_n`/`bmc_phy_rst_n`/`cpu_por_n` 0, `fault` 0, `fault_code` 0, `seq_state` 0. Reset mid-sequence returns to this state immediately (asynchronous).
- All outputs are registered and update on the same clock edge as the state register.
- Input-to-action latency: 2 synchronizer cycles plus 1 register cycle = 3 `sys_clk` cycles from an input edge to a visible output or state change.
- Delay accuracy: each delay lands within (N-1, N] ms, plus 3 cycles, because the phase of `ms_pulse` is arbitrary.
- `ms_pulse` arriving in the same cycle as a state entry is not counted by the new state.

## Test plan
Bench runs with `ms_pulse` every 10 cycles and all delay parameters left at their defaults.
- Nominal power-up: raise `vcore_en` and `vcore_pwrgd`; raise each rail's pwrgd 2 ms after its enable.
  - `p1v8_en` rises 6 ms after VCORE good; `p3v3_en` and `p1v1_en` follow the same 6 ms rule.
  - Both resets release 10 ms after P1V1 good; `cpu_por_n` releases 400 ms after P1V1 good.
  - `seq_state` ends at 9.
- PG timeout: hold `p3v3_pwrgd` low.
  - 100 ms after `p3v3_en`: FAULT, `fault_code`=2, all enables 0 within 3 cycles.
  - Drop `vcore_en`: `seq_state`=0 and `fault`=0.
- Rail loss in ON: drop `p1v8_pwrgd`.
  - `fault_code`=5, all outputs low 3 cycles later.
- Orderly power-down from ON: drop `vcore_en`.
  - `cpu_por_n`, resets and `p1v1_en` go low together.
  - `p3v3_en` clears 1 ms later, `p1v8_en` 1 ms after that, then IDLE.
- Abort mid-sequence: drop `vcore_en` in POR_WAIT.
  - PWR_DOWN runs; `cpu_por_n` never pulses high.
- Coincident events: drop `vcore_pwrgd` and `vcore_en` in the same cycle in ON.
  - FAULT with code 4, not PWR_DOWN.
- Async reset asserted in PG_3V3.
  - All outputs 0 immediately; the sequence restarts from IDLE after release.
